hist_eq_sequencer: RTL and testbench
====================================

HIST_EQ_SEQUENCER -- requirements
Module: hist_eq_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 16, scratchpad address width.
REQ-002 SHALL have parameter DATA_W, 128, scratchpad data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 100000, per-phase watchdog limit; used only with watchdog compiled in.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port go  input  1  level request to process one frame.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current frame.
REQ-008 SHALL have port ph_start  output  3  level start to engines: bit0 histogram, bit1 CDF, bit2 map.
REQ-009 SHALL have port ph_done  input  3  per-engine done level, same bit order.
REQ-010 SHALL have ports eng_m2_addr  input  3*ADDR_W, eng_m2_wdata  input  3*DATA_W, eng_m2_we  input  3: per-engine scratchpad requests, engine i in slice i.
REQ-011 SHALL have ports m2_addr  output  ADDR_W, m2_wdata  output  DATA_W, m2_we  output  1: granted scratchpad write port.
REQ-012 SHALL have port base_offset  output  1  scratchpad half for the current frame.
REQ-013 SHALL have ports busy  output  1, done  output  1, error  output  1, frame_cnt  output  8.

Function
REQ-014 SHALL implement states IDLE, HIST, CDF, MAP, FIN, ERR.
REQ-015 SHALL leave IDLE for HIST when go=1; go SHALL be ignored outside IDLE.
REQ-016 SHALL assert ph_start[i] high for every cycle spent in phase state i, low otherwise.
REQ-017 SHALL advance HIST->CDF->MAP->FIN on the first cycle the owning ph_done bit is sampled high; next ph_start rises the following cycle.
REQ-018 SHALL ignore ph_done bits of non-owning engines.
REQ-019 SHALL combinationally route the owning engine's slice to m2_addr/m2_wdata/m2_we (zero latency); outside HIST/CDF/MAP, m2_we=0 and m2_addr=0.
REQ-020 SHALL pulse done for exactly one cycle in FIN, increment frame_cnt (255 wraps to 0), toggle base_offset, then return to IDLE.
REQ-021 SHALL hold busy=1 in HIST, CDF, MAP, FIN.
REQ-022 SHALL on abort=1 in any phase state go to IDLE next cycle, dropping ph_start and m2_we, with no done, frame_cnt or base_offset change; abort beats a simultaneous ph_done.
REQ-023 SHALL in ERR hold error=1, ph_start=0, m2_we=0, and leave for IDLE only on go=0 then go=1, clearing error on exit.

Reset
REQ-024 SHALL on rst force IDLE, all outputs 0, frame_cnt=0, base_offset=0, watchdog count 0, mid-frame included.

Configuration
REQ-025 SHALL, with HIST_EQ_WATCHDOG_EN defined, count cycles in each phase state (cleared on phase entry) and enter ERR when count reaches TIMEOUT_CYCLES without ph_done.
REQ-026 SHALL, without HIST_EQ_WATCHDOG_EN, contain no counter, tie error to 0, and make ERR unreachable.

Structure
REQ-027 SHALL take the state encoding, phase index constants (PH_HIST=0, PH_CDF=1, PH_MAP=2) and width defaults from shared package hist_eq_pkg.
REQ-028 SHALL place the watchdog in sub-module hist_eq_phase_timer (clear, enable, expired).

Verification
REQ-029 SHALL cover go=1, ph_done bits raised after 10/20/30 cycles -> ph_start 001,010,100 in turn, one-cycle done, frame_cnt=1, base_offset=1.
REQ-030 SHALL cover HIST with engine0 we=1 addr=0x0042 and engine1 we=1 addr=0x0099 -> m2_addr=0x0042, m2_we=1 same cycle.
REQ-031 SHALL cover abort and ph_done[1] asserted together in CDF -> IDLE, done=0, frame_cnt unchanged.
REQ-032 SHALL cover watchdog build, TIMEOUT_CYCLES=50, ph_done never asserted -> error=1 at cycle 50 of HIST, ph_start=000; go toggle -> IDLE, error=0.
REQ-033 SHALL cover 256 back-to-back frames -> frame_cnt wraps to 0, base_offset=0.
REQ-034 SHALL cover rst pulse during MAP -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation frame sequencer.
// State encoding, engine phase indices and default widths.
package hist_eq_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 100000;

  localparam logic [1:0] PH_HIST = 2'd0;
  localparam logic [1:0] PH_CDF  = 2'd1;
  localparam logic [1:0] PH_MAP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIST,
    S_CDF,
    S_MAP,
    S_FIN,
    S_ERR
  } state_e;

  function automatic logic [2:0] ph_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/hist_eq_phase_timer.sv
// Per-phase watchdog counter, used when HIST_EQ_WATCHDOG_EN is defined.
// expired rises on the LIMIT-th enabled cycle since the last clear.
module hist_eq_phase_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expired = enable & (count == CW'(LIMIT - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hist_eq_sequencer.sv
// Frame sequencer: HIST -> CDF -> MAP engines sharing one scratchpad port.
// Optional per-phase watchdog with error state: define HIST_EQ_WATCHDOG_EN.
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                go,
  input  logic                abort,
  output logic [2:0]          ph_start,
  input  logic [2:0]          ph_done,
  input  logic [3*ADDR_W-1:0] eng_m2_addr,
  input  logic [3*DATA_W-1:0] eng_m2_wdata,
  input  logic [2:0]          eng_m2_we,
  output logic [ADDR_W-1:0]   m2_addr,
  output logic [DATA_W-1:0]   m2_wdata,
  output logic                m2_we,
  output logic                base_offset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          frame_cnt
);

  state_e     state;
  logic       in_phase;
  logic [1:0] idx;
  logic       owner_done;

  always_comb begin
    in_phase = 1'b0;
    idx      = PH_HIST;
    unique case (1'b1)
      state == S_HIST: begin in_phase = 1'b1; idx = PH_HIST; end
      state == S_CDF:  begin in_phase = 1'b1; idx = PH_CDF;  end
      state == S_MAP:  begin in_phase = 1'b1; idx = PH_MAP;  end
      default: ;
    endcase
  end

  // Only the engine owning the current phase may finish it or drive the port.
  assign owner_done = in_phase & ph_done[idx];
  assign ph_start   = in_phase ? ph_onehot(idx) : 3'b000;
  assign m2_addr    = in_phase ? eng_m2_addr[int'(idx)*ADDR_W +: ADDR_W] : '0;
  assign m2_wdata   = in_phase ? eng_m2_wdata[int'(idx)*DATA_W +: DATA_W] : '0;
  assign m2_we      = in_phase & eng_m2_we[idx];

  assign busy = in_phase | (state == S_FIN);
  assign done = (state == S_FIN);

`ifdef HIST_EQ_WATCHDOG_EN
  logic expired;
  logic go_low;

  hist_eq_phase_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .rst    (rst),
    .clear  (~in_phase | owner_done | abort),
    .enable (in_phase),
    .expired(expired)
  );

  assign error = (state == S_ERR);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      base_offset <= 1'b0;
`ifdef HIST_EQ_WATCHDOG_EN
      go_low      <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (go) state <= S_HIST;
        S_HIST, S_CDF, S_MAP: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (owner_done) begin
            state <= (state == S_HIST) ? S_CDF :
                     (state == S_CDF)  ? S_MAP : S_FIN;
          end
`ifdef HIST_EQ_WATCHDOG_EN
          else if (expired) begin
            state  <= S_ERR;
            go_low <= 1'b0;
          end
`endif
        end
        S_FIN: begin
          frame_cnt   <= frame_cnt + 8'd1;
          base_offset <= ~base_offset;
          state       <= S_IDLE;
        end
        S_ERR: begin
`ifdef HIST_EQ_WATCHDOG_EN
          // Recovery needs a fresh rising request, not a held-high go.
          if (!go) go_low <= 1'b1;
          else if (go_low) state <= S_IDLE;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Randomised bench for hist_eq_sequencer against a frame-level model.
// Watchdog checks run only when HIST_EQ_WATCHDOG_EN is defined.
module tb_hist_eq_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 128;
  localparam int TMO = 50;

  logic          clock;
  logic          rst;
  logic          go;
  logic          abort;
  logic [2:0]    ph_start;
  logic [2:0]    ph_done;
  logic [3*AW-1:0] eng_m2_addr;
  logic [3*DW-1:0] eng_m2_wdata;
  logic [2:0]    eng_m2_we;
  logic [AW-1:0] m2_addr;
  logic [DW-1:0] m2_wdata;
  logic          m2_we;
  logic          base_offset;
  logic          busy;
  logic          done;
  logic          error;
  logic [7:0]    frame_cnt;

  logic [AW-1:0] ea [3];
  logic [DW-1:0] ed [3];
  logic          ew [3];

  always_comb begin
    eng_m2_addr  = {ea[2], ea[1], ea[0]};
    eng_m2_wdata = {ed[2], ed[1], ed[0]};
    eng_m2_we    = {ew[2], ew[1], ew[0]};
  end

  hist_eq_sequencer #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .go          (go),
    .abort       (abort),
    .ph_start    (ph_start),
    .ph_done     (ph_done),
    .eng_m2_addr (eng_m2_addr),
    .eng_m2_wdata(eng_m2_wdata),
    .eng_m2_we   (eng_m2_we),
    .m2_addr     (m2_addr),
    .m2_wdata    (m2_wdata),
    .m2_we       (m2_we),
    .base_offset (base_offset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .frame_cnt   (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1..3 phase (engine mph-1), 4 finish, 5 error
  int mph   = 0;
  int mcnt  = 0;
  bit mbase = 0;
  int mcyc  = 0;
  bit golow = 0;
  bit force030 = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mph = 0; mcnt = 0; mbase = 0; mcyc = 0; golow = 0;
  endtask

  // Called at a falling edge with go/abort/ph_done already set.
  task automatic tick();
    logic [2:0] eps;
    bit inp;
    for (int i = 0; i < 3; i++) begin
      ea[i] = AW'($urandom);
      ed[i] = {$urandom, $urandom, $urandom, $urandom};
      ew[i] = 1'($urandom);
    end
    if (force030) begin
      ew[0] = 1'b1; ea[0] = 16'h0042;
      ew[1] = 1'b1; ea[1] = 16'h0099;
    end
    #1;
    inp = (mph >= 1 && mph <= 3);
    eps = inp ? 3'(1 << (mph - 1)) : 3'b000;
    chk("ph_start", 128'(ph_start), 128'(eps));
    chk("busy", 128'(busy), 128'(mph >= 1 && mph <= 4));
    chk("done", 128'(done), 128'(mph == 4));
    chk("error", 128'(error), 128'(mph == 5));
    chk("frame_cnt", 128'(frame_cnt), 128'(mcnt));
    chk("base_offset", 128'(base_offset), 128'(mbase));
    chk("m2_we", 128'(m2_we), inp ? 128'(ew[mph-1]) : 128'(0));
    chk("m2_addr", 128'(m2_addr), inp ? 128'(ea[mph-1]) : 128'(0));
    if (inp) chk("m2_wdata", m2_wdata, ed[mph-1]);
    if (force030) begin
      chk("req030_addr", 128'(m2_addr), 128'h0042);
      chk("req030_we", 128'(m2_we), 128'(1));
    end
    case (mph)
      0: if (go) begin mph = 1; mcyc = 0; end
      1, 2, 3: begin
        if (abort) mph = 0;
        else if (ph_done[mph-1]) begin mph = mph + 1; mcyc = 0; end
        else begin
`ifdef HIST_EQ_WATCHDOG_EN
          mcyc++;
          if (mcyc == TMO) begin mph = 5; golow = 0; end
`endif
        end
      end
      4: begin mcnt = (mcnt + 1) % 256; mbase = !mbase; mph = 0; end
      5: if (!go) golow = 1; else if (golow) mph = 0;
      default: mph = 0;
    endcase
    @(negedge clock);
  endtask

  // ab_ph: model phase (1..3) to abort in, 0 for none; ab_at: cycle in it.
  task automatic run_frame(input int l0, input int l1, input int l2,
                           input int ab_ph, input int ab_at, input bit f030);
    int lat [3];
    int k;
    int prev;
    lat = '{l0, l1, l2};
    go = 1'b1;
    tick();
    go = 1'b0;
    k = 0;
    for (int n = 0; n < 600 && mph != 0; n++) begin
      ph_done = 3'($urandom);
      abort = 1'b0;
      if (mph >= 1 && mph <= 3) begin
        ph_done[mph-1] = (k >= lat[mph-1]);
        abort = (mph == ab_ph && k == ab_at);
        force030 = f030 && mph == 1 && k == 0;
      end
      prev = mph;
      tick();
      force030 = 1'b0;
      k = (mph == prev) ? k + 1 : 0;
    end
    chk("frame_end", 128'(mph), 128'(0));
    abort = 1'b0;
    ph_done = 3'b000;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; ph_done = 3'b000;
    for (int i = 0; i < 3; i++) begin ea[i] = '0; ed[i] = '0; ew[i] = 1'b0; end
    model_reset();
    repeat (2) @(negedge clock);
    tick();
    rst = 1'b0;
    tick();

    run_frame(10, 20, 30, 0, 0, 1'b0);
    chk("first_cnt", 128'(frame_cnt), 128'(1));
    chk("first_base", 128'(base_offset), 128'(1));

    run_frame(2, 3, 1, 0, 0, 1'b1);

    // abort together with the CDF engine's done
    run_frame(1, 3, 5, 2, 3, 1'b0);
    chk("abort_cnt", 128'(frame_cnt), 128'(2));
    chk("abort_base", 128'(base_offset), 128'(0));
    chk("abort_idle", 128'(busy), 128'(0));

    for (int f = 0; f < 20; f++) begin
      run_frame($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 6), 1'b0);
    end

`ifdef HIST_EQ_WATCHDOG_EN
    begin
      int n;
      go = 1'b1;
      tick();
      go = 1'b0;
      n = 0;
      while (mph == 1 && n < 200) begin
        ph_done = 3'($urandom) & 3'b110;
        tick();
        n++;
      end
      ph_done = 3'b000;
      chk("wd_cycles", 128'(n), 128'(TMO));
      chk("wd_error", 128'(error), 128'(1));
      chk("wd_ph_start", 128'(ph_start), 128'(0));
      go = 1'b1; tick(); tick();
      go = 1'b0; tick();
      go = 1'b1; tick();
      go = 1'b0; tick();
      chk("wd_clear", 128'(error), 128'(0));
    end
`endif

    // reset while MAP is running
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int n = 0; n < 20 && mph != 3; n++) begin
      ph_done = 3'b011;
      tick();
    end
    ph_done = 3'b000;
    repeat (3) tick();
    chk("pre_rst_map", 128'(ph_start), 128'(3'b100));
    #2 rst = 1'b1;
    #1;
    chk("rst_ph_start", 128'(ph_start), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    chk("rst_cnt", 128'(frame_cnt), 128'(0));
    chk("rst_base", 128'(base_offset), 128'(0));
    chk("rst_we", 128'(m2_we), 128'(0));
    chk("rst_addr", 128'(m2_addr), 128'(0));
    model_reset();
    @(negedge clock);
    rst = 1'b0;
    tick();

    for (int f = 0; f < 256; f++) begin
      run_frame($urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 0, 0, 1'b0);
    end
    chk("wrap_cnt", 128'(frame_cnt), 128'(0));
    chk("wrap_base", 128'(base_offset), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
